input_cond: RTL and testbench

INPUT_COND -- requirements
Module: input_cond

---
 rtl/input_cond.sv | 136 +++++++++++++
 tb/tb_input_cond.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_cond.sv
// Input conditioning for four push-buttons and one slide switch: per-pin
// 2-flop synchronizer, debounce FSM with stable-count qualification, press/change strobes.
module input_cond #(
  parameter int unsigned DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn_raw,
  input  logic       swt_raw,
  output logic [3:0] btn_pulse,
  output logic [3:0] btn_level,
  output logic       swt_level,
  output logic       swt_chg
);

  localparam int unsigned NCH = 5;
  localparam int unsigned CW  = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

  typedef enum logic [1:0] {
    STABLE0 = 2'd0,
    PEND1   = 2'd1,
    STABLE1 = 2'd2,
    PEND0   = 2'd3
  } state_t;

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] r_sync1;
  logic [NCH-1:0] r_sync2;
  logic [NCH-1:0] w_level;
  logic [NCH-1:0] w_strobe;

  assign w_raw = {swt_raw, btn_raw};

  // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the synchronizer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    localparam bit IS_SWT = (g == NCH - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_level;
    logic          r_strobe;
    logic          w_level_nxt;
    logic          w_strobe_nxt;
    logic          w_in;

    assign w_in = r_sync2[g];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state  <= STABLE0;
        r_cnt    <= '0;
        r_level  <= 1'b0;
        r_strobe <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_cnt    <= w_cnt_nxt;
        r_level  <= w_level_nxt;
        r_strobe <= w_strobe_nxt;
      end
    end

    // NOTE: defaults first so every path assigns every output; a missed branch would otherwise infer a latch.
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
        STABLE0: begin
          if (w_in) begin
            w_state_nxt = PEND1;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        PEND1: begin
          if (!w_in) begin
            w_state_nxt = STABLE0;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_MAX) begin
            w_state_nxt = STABLE1;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
        STABLE1: begin
          if (!w_in) begin
            w_state_nxt = PEND0;
            w_cnt_nxt   = CW'(1);
          end else begin
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          if (w_in) begin
            w_state_nxt = STABLE1;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_MAX) begin
            w_state_nxt = STABLE0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CW'(1);
          end
        end
      endcase
    end

    // Level and strobe are registered from the next state so they track the FSM without an extra cycle.
    always_comb begin
      w_level_nxt  = (w_state_nxt == STABLE1) || (w_state_nxt == PEND0);
      w_strobe_nxt = IS_SWT ? (w_level_nxt != r_level) : (w_level_nxt & ~r_level);
    end

    assign w_level[g]  = r_level;
    assign w_strobe[g] = r_strobe;
  end

  assign btn_level = w_level[3:0];
  assign btn_pulse = w_strobe[3:0];
  assign swt_level = w_level[4];
  assign swt_chg   = w_strobe[4];

endmodule

// File: tb/tb_input_cond.sv
// Bench for input_cond with DEB_CYCLES=4: directed scenarios plus random
// stimulus, all checked against a run-length reference model of the debouncer.
module tb_input_cond;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn_raw;
  logic       swt_raw;
  logic [3:0] btn_pulse;
  logic [3:0] btn_level;
  logic       swt_level;
  logic       swt_chg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: synchronized sample history, debounced level, run length of disagreeing samples.
  logic [4:0] m_s1;
  logic [4:0] m_s2;
  logic [4:0] m_lvl;
  logic [4:0] m_strobe;
  int         m_run [5];

  input_cond #(.DEB_CYCLES(DEB)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .swt_raw   (swt_raw),
    .btn_pulse (btn_pulse),
    .btn_level (btn_level),
    .swt_level (swt_level),
    .swt_chg   (swt_chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_s1     = '0;
    m_s2     = '0;
    m_lvl    = '0;
    m_strobe = '0;
    for (int c = 0; c < 5; c++) m_run[c] = 0;
  endfunction

  // A level flips once the synchronized input has disagreed with it for DEB+1 straight cycles.
  function automatic void model_edge();
    logic [4:0] raw;
    logic       prev;
    logic       seen;
    raw = {swt_raw, btn_raw};
    if (!rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < 5; c++) begin
      prev    = m_lvl[c];
      seen    = m_s2[c];
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
      if (seen != prev) begin
        m_run[c]++;
        if (m_run[c] == DEB + 1) begin
          m_lvl[c] = ~prev;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_strobe[c] = (c == 4) ? (m_lvl[c] != prev) : (m_lvl[c] & ~prev);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("btn_pulse", btn_pulse, m_strobe[3:0]);
    check("btn_level", btn_level, m_lvl[3:0]);
    check("swt_level", {3'b0, swt_level}, {3'b0, m_lvl[4]});
    check("swt_chg",   {3'b0, swt_chg},   {3'b0, m_strobe[4]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int pat [9] = '{1, 1, 0, 1, 1, 1, 1, 1, 1};
    int n_early;
    int n_total;
    int n_chg;

    rst     = 1'b0;
    btn_raw = 4'b0000;
    swt_raw = 1'b0;
    model_reset();
    #1;
    check("reset_btn_level", btn_level, 4'b0000);
    check("reset_btn_pulse", btn_pulse, 4'b0000);
    check("reset_swt", {2'b0, swt_level, swt_chg}, 4'b0000);
    idle(2);
    rst = 1'b1;
    idle(3);

    // Clean press on button 0
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k < 6)  check("press0_wait",  {3'b0, btn_level[0]}, 4'b0000);
      if (k == 6) check("press0_edge6", {2'b0, btn_level[0], btn_pulse[0]}, 4'b0011);
      if (k == 7) check("press0_edge7", {2'b0, btn_level[0], btn_pulse[0]}, 4'b0010);
    end

    // Bounce on button 1
    n_early = 0;
    n_total = 0;
    for (int i = 0; i < 9; i++) begin
      btn_raw[1] = pat[i][0];
      tick();
      n_early += int'(btn_pulse[1]);
    end
    n_total = n_early;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total += int'(btn_pulse[1]);
    end
    check("bounce_no_early_pulse", 4'(n_early), 4'd0);
    check("bounce_one_pulse", 4'(n_total), 4'd1);

    // Release on button 2 after a debounced press
    btn_raw[2] = 1'b1;
    idle(8);
    check("rel2_pressed", {3'b0, btn_level[2]}, 4'b0001);
    btn_raw[2] = 1'b0;
    n_total = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_total += int'(btn_pulse[2]);
      if (k == 5) check("rel2_edge5", {3'b0, btn_level[2]}, 4'b0001);
      if (k == 6) check("rel2_edge6", {3'b0, btn_level[2]}, 4'b0000);
    end
    check("rel2_no_pulse", 4'(n_total), 4'd0);

    // Switch rise then fall
    for (int ph = 0; ph < 2; ph++) begin
      swt_raw = (ph == 0);
      n_chg = 0;
      for (int k = 0; k < 10; k++) begin
        tick();
        n_chg += int'(swt_chg);
        if (k == 5) check("swt_edge5", {3'b0, swt_level}, {3'b0, ph[0]});
        if (k == 6) check("swt_edge6", {2'b0, swt_level, swt_chg}, {2'b0, ~ph[0], 1'b1});
      end
      check("swt_one_chg", 4'(n_chg), 4'd1);
    end

    // Button 3 toggling every cycle never qualifies
    n_total = 0;
    for (int k = 0; k < 40; k++) begin
      btn_raw[3] = k[0];
      tick();
      n_total += int'(btn_pulse[3]);
    end
    check("toggle_level", {3'b0, btn_level[3]}, 4'b0000);
    check("toggle_no_pulse", 4'(n_total), 4'd0);

    // Simultaneous press on all buttons
    btn_raw = 4'b0000;
    idle(10);
    btn_raw = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 5) check("simul_edge5", btn_pulse, 4'b0000);
      if (k == 6) check("simul_edge6", btn_pulse, 4'b1111);
      if (k == 7) check("simul_edge7", btn_pulse, 4'b0000);
    end

    // Reset during PEND1 of button 3 while button 0 is held high
    btn_raw = 4'b0000;
    idle(10);
    btn_raw = 4'b0001;
    idle(10);
    btn_raw[3] = 1'b1;
    idle(4);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_async_level", btn_level, 4'b0000);
    check("rst_async_pulse", btn_pulse, 4'b0000);
    idle(2);
    rst = 1'b1;
    n_total = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      n_total += int'(btn_pulse[3]);
      if (k == 5) check("rst_rel_edge5", btn_pulse, 4'b0000);
      if (k == 6) check("rst_rel_edge6", btn_pulse, 4'b1001);
    end
    check("rst_rel_one_pulse", 4'(n_total), 4'd1);

    // Random stimulus: each pin flips with probability 1/10 per cycle
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 4; c++)
        if ($urandom_range(0, 9) == 0) btn_raw[c] = ~btn_raw[c];
      if ($urandom_range(0, 9) == 0) swt_raw = ~swt_raw;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
